// File: rtl/sha3_sponge_ctrl.sv
// SHA-3 sponge controller: absorbs an AXI-Stream message into the core's rate buffer,
// applies the 0x06 ... 0x80 padding, sequences permutations and streams the digest.
module sha3_sponge_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [WIDTH-1:0] S_TDATA,
    input  logic             S_TVALID,
    output logic             S_TREADY,
    input  logic             S_TLAST,
    input  logic [1:0]       S_TKEEP,
    input  logic [1:0]       S_TUSER,
    output logic [WIDTH-1:0] blk_data,
    output logic [6:0]       blk_addr,
    output logic             blk_we,
    output logic             state_clear,
    output logic             perm_start,
    output logic             perm_last,
    input  logic             perm_done,
    output logic [4:0]       dig_addr,
    input  logic [WIDTH-1:0] dig_data,
    output logic [WIDTH-1:0] M_TDATA,
    output logic             M_TVALID,
    input  logic             M_TREADY,
    output logic             M_TLAST
);

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PERM,
        SQ_RD,
        SQ_OUT
    } state_t;

    state_t     state;
    logic [6:0] wcnt;
    logic [1:0] mode;
    logic       msg_first;
    logic       pad06_done;
    logic       pad_next;
    logic       final_blk;

    logic [6:0] last_idx;
    logic       at_end;
    logic       beat_ok;
    logic       keep_full;

    function automatic logic [6:0] rate_words(input logic [1:0] m);
        case (m)
            2'd0:    return 7'd72;
            2'd1:    return 7'd68;
            2'd2:    return 7'd52;
            default: return 7'd36;
        endcase
    endfunction

    function automatic logic [4:0] last_dig_word(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd13;
            2'd1:    return 5'd15;
            2'd2:    return 5'd23;
            default: return 5'd31;
        endcase
    endfunction

    // A partial last beat carries the 0x06 domain byte; on the final rate word it also takes 0x80.
    function automatic logic [WIDTH-1:0] pad_beat(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] keep,
                                                  input logic end_word);
        logic [WIDTH-1:0] w;
        if (keep == 2'b11)
            w = d;
        else if (keep[0])
            w = {8'h06, d[7:0]};
        else
            w = 16'h0006;
        if (end_word && (keep != 2'b11))
            w = w | 16'h8000;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] pad_fill(input logic need06, input logic end_word);
        logic [WIDTH-1:0] w;
        w = need06 ? 16'h0006 : 16'h0000;
        if (end_word)
            w = w | 16'h8000;
        return w;
    endfunction

    assign last_idx  = rate_words(mode) - 7'd1;
    assign at_end    = (wcnt == last_idx);
    assign keep_full = (S_TKEEP == 2'b11);

    // The rate-buffer write happens in the same cycle the beat is accepted, so it stays combinational.
    assign S_TREADY = (state == ABSORB);
    assign beat_ok  = (state == ABSORB) && S_TVALID;
    assign blk_we   = beat_ok || (state == PAD);
    assign blk_addr = blk_we ? wcnt : 7'd0;
    assign blk_data = beat_ok          ? pad_beat(S_TDATA, S_TKEEP, at_end) :
                      (state == PAD)   ? pad_fill(!pad06_done, at_end) :
                                         '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            wcnt        <= '0;
            mode        <= '0;
            msg_first   <= 1'b0;
            pad06_done  <= 1'b0;
            pad_next    <= 1'b0;
            final_blk   <= 1'b0;
            state_clear <= 1'b0;
            perm_start  <= 1'b0;
            perm_last   <= 1'b0;
            dig_addr    <= '0;
            M_TDATA     <= '0;
            M_TVALID    <= 1'b0;
            M_TLAST     <= 1'b0;
        end else begin
            state_clear <= 1'b0;
            perm_start  <= 1'b0;
            perm_last   <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_clear) begin
                        state     <= ABSORB;
                        wcnt      <= '0;
                        msg_first <= 1'b1;
                    end else if (S_TVALID) begin
                        state_clear <= 1'b1;
                    end
                end
                ABSORB: begin
                    if (S_TVALID) begin
                        if (msg_first) begin
                            mode      <= S_TUSER;
                            msg_first <= 1'b0;
                        end
                        if (!S_TLAST) begin
                            if (at_end) begin
                                state      <= PERM;
                                perm_start <= 1'b1;
                                final_blk  <= 1'b0;
                                pad_next   <= 1'b0;
                                wcnt       <= '0;
                            end else begin
                                wcnt <= wcnt + 7'd1;
                            end
                        end else if (at_end && keep_full) begin
                            // Block is full with no room for padding: a whole pad block follows.
                            state      <= PERM;
                            perm_start <= 1'b1;
                            final_blk  <= 1'b0;
                            pad_next   <= 1'b1;
                            wcnt       <= '0;
                        end else if (at_end) begin
                            state      <= PERM;
                            perm_start <= 1'b1;
                            perm_last  <= 1'b1;
                            final_blk  <= 1'b1;
                            wcnt       <= '0;
                        end else begin
                            state      <= PAD;
                            wcnt       <= wcnt + 7'd1;
                            pad06_done <= !keep_full;
                        end
                    end
                end
                PAD: begin
                    pad06_done <= 1'b1;
                    if (at_end) begin
                        state      <= PERM;
                        perm_start <= 1'b1;
                        perm_last  <= 1'b1;
                        final_blk  <= 1'b1;
                        wcnt       <= '0;
                    end else begin
                        wcnt <= wcnt + 7'd1;
                    end
                end
                PERM: begin
                    if (perm_done) begin
                        wcnt <= '0;
                        if (final_blk) begin
                            state    <= SQ_RD;
                            dig_addr <= '0;
                        end else if (pad_next) begin
                            state      <= PAD;
                            pad06_done <= 1'b0;
                            pad_next   <= 1'b0;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                SQ_RD: begin
                    state <= SQ_OUT;
                end
                SQ_OUT: begin
                    // First SQ_OUT cycle captures the read word; later cycles wait for the handshake.
                    if (!M_TVALID) begin
                        M_TDATA  <= dig_data;
                        M_TVALID <= 1'b1;
                        M_TLAST  <= (dig_addr == last_dig_word(mode));
                    end else if (M_TREADY) begin
                        M_TVALID <= 1'b0;
                        M_TLAST  <= 1'b0;
                        if (M_TLAST) begin
                            state     <= IDLE;
                            dig_addr  <= '0;
                            final_blk <= 1'b0;
                        end else begin
                            dig_addr <= dig_addr + 5'd1;
                            state    <= SQ_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Bench for sha3_sponge_ctrl: random messages checked against a byte-level SHA-3 padding model,
// with a behavioural permutation core and digest memory around the controller.
module tb_sha3_sponge_ctrl;

    logic        ACLK;
    logic        ARESET;
    logic [15:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TREADY;
    logic        S_TLAST;
    logic [1:0]  S_TKEEP;
    logic [1:0]  S_TUSER;
    logic [15:0] blk_data;
    logic [6:0]  blk_addr;
    logic        blk_we;
    logic        state_clear;
    logic        perm_start;
    logic        perm_last;
    logic        perm_done;
    logic [4:0]  dig_addr;
    logic [15:0] dig_data;
    logic [15:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        M_TLAST;

    logic        core_done;
    logic        inj_done;
    assign perm_done = core_done | inj_done;

    logic [15:0] dig_mem [32];
    int          rate_tab [4] = '{72, 68, 52, 36};
    int          dig_tab  [4] = '{14, 16, 24, 32};
    logic [7:0]  msg [$];
    logic [22:0] wr_q [$];
    bit          perm_q [$];
    int          clr_cnt;
    int          excl_viol;
    int          wr_base, perm_base, clr_base, excl_base;
    int          vectors;
    int          miscompares;

    sha3_sponge_ctrl #(.WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TLAST(S_TLAST),
        .S_TKEEP(S_TKEEP), .S_TUSER(S_TUSER),
        .blk_data(blk_data), .blk_addr(blk_addr), .blk_we(blk_we),
        .state_clear(state_clear),
        .perm_start(perm_start), .perm_last(perm_last), .perm_done(perm_done),
        .dig_addr(dig_addr), .dig_data(dig_data),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Digest memory with one cycle of read latency
    always @(posedge ACLK) dig_data <= dig_mem[dig_addr];

    // Records every rate-buffer write, permutation request and clear pulse
    initial begin
        clr_cnt   = 0;
        excl_viol = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (blk_we) wr_q.push_back({blk_addr, blk_data});
                if (perm_start) perm_q.push_back(perm_last);
                if (state_clear) clr_cnt++;
                if ((int'(blk_we) + int'(perm_start) + int'(state_clear)) > 1) excl_viol++;
                if (state_clear && S_TREADY) excl_viol++;
                if (perm_last && !perm_start) excl_viol++;
            end
        end
    end

    // Permutation core: completes 1..4 cycles after each start
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge ACLK);
            if (perm_start && !ARESET) begin
                repeat ($urandom_range(0, 3)) @(posedge ACLK);
                @(posedge ACLK); #1 core_done = 1'b1;
                @(posedge ACLK); #1 core_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tready"},  32'(S_TREADY), 0);
        check({tag, "_blk_we"},  32'(blk_we), 0);
        check({tag, "_blk_addr"}, 32'(blk_addr), 0);
        check({tag, "_blk_data"}, 32'(blk_data), 0);
        check({tag, "_clear"},   32'(state_clear), 0);
        check({tag, "_pstart"},  32'(perm_start), 0);
        check({tag, "_plast"},   32'(perm_last), 0);
        check({tag, "_dig_addr"}, 32'(dig_addr), 0);
        check({tag, "_m_tdata"}, 32'(M_TDATA), 0);
        check({tag, "_m_tvalid"}, 32'(M_TVALID), 0);
        check({tag, "_m_tlast"}, 32'(M_TLAST), 0);
    endtask

    task automatic make_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) dig_mem[i] = 16'($urandom);
    endtask

    task automatic mark_bases();
        wr_base   = wr_q.size();
        perm_base = perm_q.size();
        clr_base  = clr_cnt;
        excl_base = excl_viol;
    endtask

    // Sends msg as beats; user_sw switches S_TUSER to 3 from that beat, inject_at pulses a stray
    // perm_done before that beat, abort_after stops after that many accepted beats.
    task automatic send_msg(input int mode, input bit empty_tail, input int user_sw,
                            input int inject_at, input int abort_after, input int gap);
        int nb;
        int nbeats;
        int cyc;
        nb = msg.size();
        nbeats = (nb + 1) / 2;
        if ((nb % 2 == 0) && (empty_tail || nb == 0)) nbeats++;
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_after) return;
            if (b == inject_at) begin
                inj_done = 1'b1;
                @(posedge ACLK); #1;
                inj_done = 1'b0;
            end
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                S_TVALID = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge ACLK);
                #1;
            end
            if (2 * b + 1 < nb) begin
                S_TDATA = {msg[2*b+1], msg[2*b]};
                S_TKEEP = 2'b11;
            end else if (2 * b < nb) begin
                S_TDATA = {8'($urandom), msg[2*b]};
                S_TKEEP = 2'b01;
            end else begin
                S_TDATA = 16'($urandom);
                S_TKEEP = 2'b00;
            end
            S_TLAST  = (b == nbeats - 1);
            S_TUSER  = (user_sw >= 0 && b >= user_sw) ? 2'd3 : 2'(mode);
            S_TVALID = 1'b1;
            cyc = 0;
            forever begin
                @(negedge ACLK);
                cyc++;
                if (S_TREADY || cyc > 1000) break;
            end
            if (!S_TREADY) begin
                check("send_timeout", 32'(cyc), 0);
                S_TVALID = 1'b0;
                return;
            end
            @(posedge ACLK); #1;
            S_TVALID = 1'b0;
            S_TLAST  = 1'b0;
        end
    endtask

    task automatic recv_digest(input string tag, input int dwords, input int stall_word);
        int w;
        int cyc;
        int stall;
        w = 0;
        cyc = 0;
        stall = 0;
        while (w < dwords && cyc < 4000) begin
            @(posedge ACLK); #1;
            if (M_TVALID && w == stall_word && stall < 5) begin
                M_TREADY = 1'b0;
                stall++;
            end else begin
                M_TREADY = ($urandom_range(0, 3) != 0);
            end
            @(negedge ACLK);
            cyc++;
            if (M_TVALID && !M_TREADY && w == stall_word) begin
                check({tag, "_stall_data"}, 32'(M_TDATA), 32'(dig_mem[w]));
                check({tag, "_stall_addr"}, 32'(dig_addr), w);
            end
            if (M_TVALID && M_TREADY) begin
                check($sformatf("%s_dig%0d", tag, w), 32'(M_TDATA), 32'(dig_mem[w]));
                check($sformatf("%s_last%0d", tag, w), 32'(M_TLAST), (w == dwords - 1) ? 1 : 0);
                check($sformatf("%s_daddr%0d", tag, w), 32'(dig_addr), w);
                w++;
            end
        end
        @(posedge ACLK); #1;
        M_TREADY = 1'b0;
        check({tag, "_words"}, w, dwords);
        if (stall_word >= 0) check({tag, "_stall_cycles"}, stall, 5);
        repeat (3) @(negedge ACLK);
        check({tag, "_no_extra"}, 32'(M_TVALID), 0);
    endtask

    // Reference: SHA-3 byte padding of msg, packed two bytes per word, split into rate blocks
    task automatic check_msg(input string tag, input int mode);
        logic [7:0]  pad [$];
        logic [22:0] e;
        int          r;
        int          nwords;
        int          nblk;
        r = rate_tab[mode];
        pad = msg;
        pad.push_back(8'h06);
        while (pad.size() % (2 * r) != 0) pad.push_back(8'h00);
        pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
        nwords = pad.size() / 2;
        nblk = pad.size() / (2 * r);
        check({tag, "_nwrites"}, wr_q.size() - wr_base, nwords);
        for (int i = 0; i < nwords && wr_base + i < wr_q.size(); i++) begin
            e = wr_q[wr_base + i];
            check($sformatf("%s_addr%0d", tag, i), 32'(e[22:16]), i % r);
            check($sformatf("%s_word%0d", tag, i), 32'(e[15:0]), 32'({pad[2*i+1], pad[2*i]}));
        end
        check({tag, "_nperm"}, perm_q.size() - perm_base, nblk);
        for (int i = 0; i < nblk && perm_base + i < perm_q.size(); i++)
            check($sformatf("%s_plast%0d", tag, i), 32'(perm_q[perm_base + i]), (i == nblk - 1) ? 1 : 0);
        check({tag, "_clears"}, clr_cnt - clr_base, 1);
        check({tag, "_exclusive"}, excl_viol - excl_base, 0);
        mark_bases();
    endtask

    task automatic run_msg(input string tag, input int mode, input bit empty_tail, input int user_sw,
                           input int inject_at, input int gap, input int stall_word);
        fill_mem();
        send_msg(mode, empty_tail, user_sw, inject_at, -1, gap);
        recv_digest(tag, dig_tab[mode], stall_word);
        check_msg(tag, mode);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_base = 0; perm_base = 0; clr_base = 0; excl_base = 0;
        ARESET   = 1'b1;
        S_TDATA  = '0;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        S_TKEEP  = 2'b00;
        S_TUSER  = 2'd0;
        M_TREADY = 1'b0;
        inj_done = 1'b0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_outputs_zero("rst");
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Empty message, mode 1, with a 5-cycle output stall on word 3
        make_msg(0);
        run_msg("empty_m1", 1, 1'b1, -1, -1, 0, 3);

        // 67 full beats plus a one-byte last beat landing on the final rate word
        make_msg(135);
        msg[134] = 8'hAB;
        run_msg("odd_end_m1", 1, 1'b0, -1, -1, 0, -1);

        // Exactly one full block in mode 3: padding needs a second block
        make_msg(72);
        run_msg("full_blk_m3", 3, 1'b0, -1, -1, 0, -1);

        // Empty last beat on the final rate word (0x8006), and full last beat one word short
        make_msg(102);
        run_msg("empty_end_m2", 2, 1'b1, -1, -1, 0, -1);
        make_msg(142);
        run_msg("near_end_m0", 0, 1'b0, -1, -1, 0, -1);

        // Asynchronous reset in the middle of absorbing
        make_msg(200);
        fill_mem();
        send_msg(1, 1'b0, -1, -1, 10, 0);
        check("abort_in_absorb", 32'(S_TREADY), 1);
        S_TDATA  = 16'($urandom);
        S_TKEEP  = 2'b11;
        S_TVALID = 1'b1;
        #3 ARESET = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge ACLK);
        #1;
        S_TVALID = 1'b0;
        ARESET   = 1'b0;
        @(posedge ACLK); #1;
        mark_bases();
        make_msg(60);
        run_msg("after_rst_m1", 1, 1'b0, -1, -1, 0, -1);

        // Mode change mid-message and a stray perm_done while absorbing
        make_msg(150);
        run_msg("user_sw_m1", 1, 1'b0, 3, 5, 0, -1);

        // Randomised messages with input gaps and output back-pressure
        for (int t = 0; t < 6; t++) begin
            int mode;
            int nb;
            mode = $urandom_range(0, 3);
            nb = $urandom_range(0, 4 * rate_tab[mode] + 5);
            make_msg(nb);
            run_msg($sformatf("rand%0d_m%0d", t, mode), mode, 1'($urandom_range(0, 1)), -1, -1, 30,
                    $urandom_range(0, dig_tab[mode] - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
